// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit that owns the HI/LO pair.
// Three-state FSM (IDLE/MUL/DIV) counts down a fixed latency and then
// commits the result to HI/LO in a single edge. MTHI/MTLO write in one cycle.
// Optional macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 6-9);
// without it those codes are NOPs.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state, state_n;
    logic [5:0]       cnt, cnt_n;
    logic             load, commit;
    logic             mul_op, div_op;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;

    logic                 sgn_mul;
    logic [2*WIDTH-1:0]   ea, eb, prod, acc, mul_full;
    logic [WIDTH-1:0]     div_hi, div_lo;

    assign busy = (state != IDLE);

    // Decode which ops launch a multi-cycle operation.
    always_comb begin
        mul_op = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        mul_op = mul_op || (op == OP_MADD) || (op == OP_MADDU) ||
                 (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        div_op = (op == OP_DIV) || (op == OP_DIVU);
    end

    // State and latency counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: launch from IDLE, count down, commit when the count hits 1.
    // Starts seen while busy are dropped on the floor.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (start && mul_op) begin
                    state_n = MUL;
                    cnt_n   = 6'(MULT_CYCLES);
                    load    = 1'b1;
                end else if (start && div_op) begin
                    state_n = DIV;
                    cnt_n   = 6'(DIV_CYCLES);
                    load    = 1'b1;
                end
            end
            MUL, DIV: begin
                if (cnt == 6'd1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_n = cnt - 6'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Capture operands and op at launch so later input changes are harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (load) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end
    end

    // Multiply / accumulate result. HI/LO cannot change while busy, so the
    // live {hi,lo} equals the accumulator value seen at the launch edge.
    always_comb begin
        sgn_mul  = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
        ea       = {{WIDTH{sgn_mul & a_q[WIDTH-1]}}, a_q};
        eb       = {{WIDTH{sgn_mul & b_q[WIDTH-1]}}, b_q};
        prod     = ea * eb;
        acc      = {hi, lo};
        case (op_q)
            OP_MADD, OP_MADDU: mul_full = acc + prod;
            OP_MSUB, OP_MSUBU: mul_full = acc - prod;
            default:           mul_full = prod;
        endcase
    end

    // Divide result with the two architectural corner cases pinned down.
    always_comb begin
        div_hi = '0;
        div_lo = '0;
        if (b_q == '0) begin
            div_hi = a_q;
            div_lo = '1;
        end else if (op_q == OP_DIV && a_q == MOST_NEG && b_q == '1) begin
            div_hi = '0;
            div_lo = a_q;
        end else if (op_q == OP_DIV) begin
            div_lo = $signed(a_q) / $signed(b_q);
            div_hi = $signed(a_q) % $signed(b_q);
        end else begin
            div_lo = a_q / b_q;
            div_hi = a_q % b_q;
        end
    end

    // HI/LO: full commit at the end of a multi-cycle op, or a direct move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (state == MUL) begin
                hi <= mul_full[2*WIDTH-1:WIDTH];
                lo <= mul_full[WIDTH-1:0];
            end else begin
                hi <= div_hi;
                lo <= div_lo;
            end
        end else if (state == IDLE && start) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
        end
    end

endmodule
